sd_spi: RTL and testbench
=========================

SD_SPI -- requirements
Module: sd_spi

Interface
REQ-001 Parameter CLKDIV, default 4: SCK half-period in clock cycles, legal range 1..255.
REQ-002 Parameter TIMEOUT_CYC, default 25000000: idle-with-CS-asserted cycles before timeout, 32-bit.
REQ-003 clock  input  1  system clock; all logic on posedge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 sd_signal  input  1  single-cycle command strobe from memory/port map.
REQ-006 sd_cmd  input  2  command code, sampled when sd_signal=1.
REQ-007 sd_out  input  8  byte to transmit, sampled when sd_signal=1.
REQ-008 sd_din  output  8  last byte received from card.
REQ-009 sd_busy  output  1  =1 while a command executes.
REQ-010 sd_timeout  output  1  =1 when the card has been left selected and idle too long.
REQ-011 spi_cs_n  output  1  card chip select, active-low.
REQ-012 spi_sck  output  1  SPI clock, mode 0 (idle low).
REQ-013 spi_mosi  output  1  serial data to card.
REQ-014 spi_miso  input  1  serial data from card.

Function
REQ-015 Command accepted SHALL require sd_signal=1 and sd_busy=0; strobes while busy SHALL be ignored with no state change.
REQ-016 States SHALL be IDLE, INIT, XFER; sd_busy=1 exactly when state is INIT or XFER.
REQ-017 Cmd 0 (INIT): IDLE->INIT; spi_cs_n forced 1, spi_mosi held 1, 80 full SCK periods, then ->IDLE; duration 160*CLKDIV cycles.
REQ-018 Cmd 1 (XFER): IDLE->XFER; 8 bits MSB first; duration 16*CLKDIV cycles; spi_cs_n unchanged.
REQ-019 Cmd 2: spi_cs_n<=0 on the accept edge; state stays IDLE; sd_busy stays 0.
REQ-020 Cmd 3: spi_cs_n<=1 on the accept edge; state stays IDLE; sd_busy stays 0.
REQ-021 Accepting a strobe at edge T SHALL make sd_busy=1 from T+1 (cmd 0/1) and spi_mosi=sd_out[7] from T+1 (cmd 1).
REQ-022 Each bit: SCK low for CLKDIV cycles, then high for CLKDIV cycles; spi_miso sampled on the clock edge that raises SCK.
REQ-023 spi_mosi SHALL change only on the edge that lowers SCK (or at T+1 for bit 7); after the last bit spi_mosi returns to 1.
REQ-024 sd_din SHALL update with the full received byte on the same edge that clears sd_busy; it SHALL hold its value otherwise.
REQ-025 Timeout counter SHALL clear on every accepted command, count each cycle while state=IDLE and spi_cs_n=0, and saturate at TIMEOUT_CYC.
REQ-026 sd_timeout SHALL become 1 when the counter reaches TIMEOUT_CYC and stay 1 (sticky) until the next accepted command, which clears it on the accept edge.
REQ-027 sd_cmd values outside 0..3 are impossible (2-bit); port writes wider than 2 bits are truncated upstream.

Reset
REQ-028 When reset_n=0 on an edge: state IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=1, sd_din=8'hFF, sd_busy=0, sd_timeout=0, timeout counter and bit/divider counters 0.
REQ-029 Reset SHALL take priority over any strobe in the same cycle and SHALL abort an INIT/XFER mid-operation without updating sd_din.

Structure
REQ-030 Command codes SD_CMD_INIT=0, SD_CMD_XFER=1, SD_CMD_SEL=2, SD_CMD_DESEL=3 and state encodings SHALL live in a shared package/include sd_pkg, used also by the port map.
REQ-031 SCK half-period tick SHALL come from one sub-module sd_spi_clkdiv (counter, enable input, tick output), restarted on each accepted command.

Verification
REQ-032 Reset: hold reset_n=0 2 cycles -> spi_cs_n=1, spi_sck=0, spi_mosi=1, sd_din=FF, sd_busy=0, sd_timeout=0.
REQ-033 CLKDIV=2, miso looped to mosi: cmd 2, then cmd 1 with sd_out=A5 -> spi_cs_n=0, exactly 8 SCK rises, sd_busy high 32 cycles, sd_din=A5 on busy fall.
REQ-034 CLKDIV=2, cmd 0 -> 80 SCK rises with spi_cs_n=1 and spi_mosi=1 throughout, sd_busy high exactly 320 cycles.
REQ-035 CLKDIV=2, cmd 1 sd_out=3C, second strobe sd_out=00 at cycle 10 -> ignored; sd_din=3C; busy falls at cycle 32.
REQ-036 TIMEOUT_CYC=100: cmd 2, idle 100 cycles -> sd_timeout=1; then cmd 1 -> sd_timeout=0 on the accept edge.
REQ-037 CLKDIV=2, cmd 1 sd_out=FF with miso=0, reset_n=0 after 4 bits -> next cycle all REQ-028 values, sd_din=FF.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card SPI engine and its port map.
// Holds the command codes written through the port map, the engine's state
// encoding and the fixed card-init clock count.
package sd_pkg;

  // Command codes carried on sd_cmd.
  localparam logic [1:0] SD_CMD_INIT  = 2'd0;
  localparam logic [1:0] SD_CMD_XFER  = 2'd1;
  localparam logic [1:0] SD_CMD_SEL   = 2'd2;
  localparam logic [1:0] SD_CMD_DESEL = 2'd3;

  // Number of full SCK periods sent with CS high to wake the card.
  localparam int unsigned INIT_CLOCKS = 80;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StInit = 2'd1,
    StXfer = 2'd2
  } sd_state_e;

endpackage

// File: rtl/sd_spi_clkdiv.sv
// SCK half-period tick generator for sd_spi.
// Ports:
//   clock, reset_n : system clock, synchronous active-low reset
//   enable         : count while high (engine busy)
//   restart        : zero the counter (command accepted)
//   tick           : one-cycle pulse every CLKDIV enabled cycles
module sd_spi_clkdiv #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] Last = 8'(CLKDIV - 1);

  logic [7:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (restart) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= (count == Last) ? 8'd0 : count + 8'd1;
    end
  end

  assign tick = enable && !restart && (count == Last);

endmodule

// File: rtl/sd_spi.sv
// SD-card SPI master (mode 0) driven by single-cycle command strobes.
// Commands: INIT (80 SCK periods with CS high, MOSI high), XFER (one byte,
// MSB first, full duplex), SEL / DESEL (drive chip select).
// Ports:
//   clock, reset_n        : system clock, synchronous active-low reset
//   sd_signal, sd_cmd     : command strobe and code
//   sd_out                : byte to send on XFER
//   sd_din                : last byte received
//   sd_busy               : INIT or XFER in progress
//   sd_timeout            : card left selected and idle too long (sticky)
//   spi_cs_n, spi_sck, spi_mosi, spi_miso : SPI pins
module sd_spi
  import sd_pkg::*;
#(
  parameter int unsigned CLKDIV      = 4,
  parameter int unsigned TIMEOUT_CYC = 25000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sd_signal,
  input  logic [1:0] sd_cmd,
  input  logic [7:0] sd_out,
  output logic [7:0] sd_din,
  output logic       sd_busy,
  output logic       sd_timeout,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [31:0] TimeoutMax = 32'(TIMEOUT_CYC);
  localparam logic [6:0]  InitLast   = 7'(INIT_CLOCKS - 1);
  localparam logic [6:0]  XferLast   = 7'd7;

  sd_state_e  state;
  logic [6:0] bit_cnt;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [31:0] to_cnt;
  logic [32:0] to_next;
  logic       accept;
  logic       tick;

  assign accept  = sd_signal && (state == StIdle);
  assign sd_busy = (state != StIdle);
  assign to_next = {1'b0, to_cnt} + 33'd1;

  sd_spi_clkdiv #(
    .CLKDIV(CLKDIV)
  ) u_clkdiv (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (sd_busy),
    .restart(accept),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= StIdle;
      spi_cs_n   <= 1'b1;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b1;
      sd_din     <= 8'hFF;
      sd_timeout <= 1'b0;
      to_cnt     <= 32'd0;
      bit_cnt    <= 7'd0;
      tx_shift   <= 8'd0;
      rx_shift   <= 8'd0;
    end else begin
      // Idle-while-selected watchdog; any accepted command rearms it.
      if (accept) begin
        to_cnt     <= 32'd0;
        sd_timeout <= 1'b0;
      end else if (state == StIdle && !spi_cs_n) begin
        if (to_cnt < TimeoutMax) to_cnt <= to_next[31:0];
        if (to_next >= {1'b0, TimeoutMax}) sd_timeout <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (sd_signal) begin
            case (sd_cmd)
              SD_CMD_INIT: begin
                state    <= StInit;
                spi_cs_n <= 1'b1;
                spi_mosi <= 1'b1;
                spi_sck  <= 1'b0;
                bit_cnt  <= 7'd0;
              end
              SD_CMD_XFER: begin
                state    <= StXfer;
                spi_mosi <= sd_out[7];
                tx_shift <= {sd_out[6:0], 1'b0};
                spi_sck  <= 1'b0;
                bit_cnt  <= 7'd0;
              end
              SD_CMD_SEL:   spi_cs_n <= 1'b0;
              SD_CMD_DESEL: spi_cs_n <= 1'b1;
              default:      spi_cs_n <= spi_cs_n;
            endcase
          end
        end

        StInit: begin
          if (tick) begin
            if (!spi_sck) begin
              spi_sck <= 1'b1;
            end else begin
              spi_sck <= 1'b0;
              if (bit_cnt == InitLast) state <= StIdle;
              else bit_cnt <= bit_cnt + 7'd1;
            end
          end
        end

        StXfer: begin
          if (tick) begin
            if (!spi_sck) begin
              // Rising SCK: card data is stable, sample it.
              spi_sck  <= 1'b1;
              rx_shift <= {rx_shift[6:0], spi_miso};
            end else begin
              // Falling SCK: present the next bit, or finish the byte.
              spi_sck <= 1'b0;
              if (bit_cnt == XferLast) begin
                state    <= StIdle;
                sd_din   <= rx_shift;
                spi_mosi <= 1'b1;
              end else begin
                bit_cnt  <= bit_cnt + 7'd1;
                spi_mosi <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi.sv
module tb_sd_spi;
  import sd_pkg::*;

  localparam int unsigned CLKDIV  = 2;
  localparam int unsigned TIMEOUT = 100;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       sd_signal;
  logic [1:0] sd_cmd;
  logic [7:0] sd_out;
  logic [7:0] sd_din;
  logic       sd_busy;
  logic       sd_timeout;
  logic       spi_cs_n;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       loopback;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  assign spi_miso = loopback ? spi_mosi : 1'b0;

  always #5 clock = ~clock;

  sd_spi #(
    .CLKDIV     (CLKDIV),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .sd_signal (sd_signal),
    .sd_cmd    (sd_cmd),
    .sd_out    (sd_out),
    .sd_din    (sd_din),
    .sd_busy   (sd_busy),
    .sd_timeout(sd_timeout),
    .spi_cs_n  (spi_cs_n),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present a strobe for one cycle; returns just after the accept edge.
  task automatic strobe(input logic [1:0] cmd, input logic [7:0] data);
    sd_signal = 1'b1;
    sd_cmd    = cmd;
    sd_out    = data;
    if (cmd == SD_CMD_XFER) exp_q.push_back(loopback ? data : 8'h00);
    step(1);
    sd_signal = 1'b0;
  endtask

  // Follow a busy period; optionally fire a stray XFER strobe of 00 so that
  // it is seen on the edge `inject_at` cycles after the accept edge.
  task automatic watch_busy(input int inject_at, output int cycles, output int rises,
                            output int pin_bad);
    logic prev;
    cycles  = 0;
    rises   = 0;
    pin_bad = 0;
    prev    = spi_sck;
    while (sd_busy && cycles < 2000) begin
      if (spi_cs_n !== 1'b1 || spi_mosi !== 1'b1) pin_bad++;
      sd_signal = (cycles + 1 == inject_at);
      if (sd_signal) begin
        sd_cmd = SD_CMD_XFER;
        sd_out = 8'h00;
      end
      step(1);
      cycles++;
      if (spi_sck && !prev) rises++;
      prev = spi_sck;
    end
    sd_signal = 1'b0;
  endtask

  task automatic finish_xfer(input string tag, input int cycles, input int rises);
    check({tag, "_busy_len"}, cycles, 16 * CLKDIV);
    check({tag, "_sck_rises"}, rises, 8);
    check({tag, "_mosi_idle"}, spi_mosi, 1'b1);
    check({tag, "_sck_idle"}, spi_sck, 1'b0);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
    else check({tag, "_sd_din"}, sd_din, exp_q.pop_front());
  endtask

  initial begin : main
    int cyc;
    int rises;
    int pin_bad;
    logic [7:0] pats [4] = '{8'hA5, 8'h00, 8'h81, 8'h5A};

    reset_n   = 1'b0;
    sd_signal = 1'b0;
    sd_cmd    = 2'd0;
    sd_out    = 8'h00;
    loopback  = 1'b1;
    step(2);
    check("rst_cs_n", spi_cs_n, 1'b1);
    check("rst_sck", spi_sck, 1'b0);
    check("rst_mosi", spi_mosi, 1'b1);
    check("rst_din", sd_din, 8'hFF);
    check("rst_busy", sd_busy, 1'b0);
    check("rst_timeout", sd_timeout, 1'b0);
    reset_n = 1'b1;
    step(1);

    // Select, then loopback transfers over several patterns.
    strobe(SD_CMD_SEL, 8'h00);
    check("sel_cs_n", spi_cs_n, 1'b0);
    check("sel_busy", sd_busy, 1'b0);
    foreach (pats[i]) begin
      strobe(SD_CMD_XFER, pats[i]);
      check("xfer_busy_start", sd_busy, 1'b1);
      check("xfer_mosi_msb", spi_mosi, pats[i][7]);
      watch_busy(-1, cyc, rises, pin_bad);
      check("xfer_cs_n", spi_cs_n, 1'b0);
      finish_xfer("xfer", cyc, rises);
      step(2);
    end

    // A strobe while busy must be ignored.
    strobe(SD_CMD_XFER, 8'h3C);
    watch_busy(10, cyc, rises, pin_bad);
    finish_xfer("ignore", cyc, rises);
    step(1);
    check("ignore_no_restart", sd_busy, 1'b0);

    // Card init: CS and MOSI high for 80 SCK periods.
    strobe(SD_CMD_DESEL, 8'h00);
    check("desel_cs_n", spi_cs_n, 1'b1);
    strobe(SD_CMD_SEL, 8'h00);
    strobe(SD_CMD_INIT, 8'h00);
    check("init_busy_start", sd_busy, 1'b1);
    watch_busy(-1, cyc, rises, pin_bad);
    check("init_busy_len", cyc, 160 * CLKDIV);
    check("init_sck_rises", rises, 80);
    check("init_pins_high", pin_bad, 0);
    check("init_din_held", sd_din, 8'h3C);

    // Watchdog: selected and idle for TIMEOUT cycles.
    strobe(SD_CMD_SEL, 8'h00);
    step(TIMEOUT - 1);
    check("to_before", sd_timeout, 1'b0);
    step(1);
    check("to_set", sd_timeout, 1'b1);
    step(5);
    check("to_sticky", sd_timeout, 1'b1);
    strobe(SD_CMD_XFER, 8'h5A);
    check("to_clear", sd_timeout, 1'b0);
    watch_busy(-1, cyc, rises, pin_bad);
    finish_xfer("to_xfer", cyc, rises);

    // Reset in the middle of a transfer aborts without touching sd_din.
    loopback = 1'b0;
    strobe(SD_CMD_XFER, 8'hFF);
    step(8 * CLKDIV - 1);
    check("abort_busy_mid", sd_busy, 1'b1);
    check("abort_din_held", sd_din, 8'h5A);
    reset_n = 1'b0;
    step(1);
    check("abort_cs_n", spi_cs_n, 1'b1);
    check("abort_sck", spi_sck, 1'b0);
    check("abort_mosi", spi_mosi, 1'b1);
    check("abort_din", sd_din, 8'hFF);
    check("abort_busy", sd_busy, 1'b0);
    check("abort_timeout", sd_timeout, 1'b0);
    exp_q.delete();
    reset_n = 1'b1;
    step(3);
    check("abort_stays_idle", sd_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
